uart_hex_entry_buffer: RTL and testbench

//  Consumes ASCII bytes from the UART receiver and builds up to 8 hex digits of keyboard entry.

---
 rtl/uart_hex_entry_buffer.sv | 148 ++++++++++++++
 tb/tb_uart_hex_entry_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_entry_buffer.sv
// Hex keypad entry from UART bytes, driving an 8-digit seven-segment display and publishing committed values.
// One byte per 2 cycles (rx_ready low while decoding); err/value_valid one cycle after decode, display one cycle later.
module uart_hex_entry_buffer #(
  parameter int ERR_CYCLES = 50_000_000,
  parameter bit LF_COMMITS = 1'b1
) (
  input  logic        CLOCK_100,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] hex_digits,
  output logic [7:0]  blank,
  output logic [7:0]  dec_points,
  output logic [31:0] value,
  output logic        value_valid,
  output logic        err
);

  localparam int TW = $clog2(ERR_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ERR_CYCLES - 1);

  typedef enum logic {IDLE, DECODE} state_t;

  state_t        state, state_nxt;
  logic          capture, apply;
  logic [7:0]    rx_q;
  logic [31:0]   digits;
  logic [3:0]    cnt;
  logic          show;
  logic [TW-1:0] timer;

  logic          is_hex, is_bs, is_esc, is_commit, reject;
  logic [3:0]    nib;
  logic [7:0]    entry_blank, lz_blank;
  logic          seen;

  always_ff @(posedge CLOCK_100 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    capture   = 1'b0;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          capture   = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        apply     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Letters map via the low nibble: 'A'/'a' end in 1, so +9 gives 0xA.
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (rx_q >= 8'h30 && rx_q <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_q[3:0];
    end else if ((rx_q >= 8'h41 && rx_q <= 8'h46) || (rx_q >= 8'h61 && rx_q <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_q[3:0] + 4'd9;
    end
    is_bs     = (rx_q == 8'h08) || (rx_q == 8'h7F);
    is_esc    = (rx_q == 8'h1B);
    is_commit = (rx_q == 8'h0D) || (LF_COMMITS && rx_q == 8'h0A);
    reject    = (is_hex && cnt == 4'd8) || (is_bs && cnt == 4'd0) ||
                !(is_hex || is_bs || is_esc || is_commit);
  end

  always_comb begin
    entry_blank = 8'h00;
    for (int i = 1; i < 8; i++) entry_blank[i] = (4'(i) >= cnt);
  end

  // Leading-zero suppression walks down from the top digit; digit 0 always shows.
  always_comb begin
    lz_blank = 8'h00;
    seen     = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      seen        = seen | (value[i*4 +: 4] != 4'h0);
      lz_blank[i] = !seen;
    end
  end

  always_ff @(posedge CLOCK_100 or negedge reset_n) begin
    if (!reset_n) begin
      rx_q        <= 8'h00;
      digits      <= 32'h0;
      cnt         <= 4'd0;
      show        <= 1'b0;
      timer       <= '0;
      value       <= 32'h0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      hex_digits  <= 32'h0;
      blank       <= 8'hFE;
      dec_points  <= 8'h00;
    end else begin
      err         <= 1'b0;
      value_valid <= 1'b0;
      if (capture) rx_q <= rx_data;

      if (apply && reject)  timer <= TIMER_LOAD;
      else if (timer != '0) timer <= timer - TW'(1);

      if (apply) begin
        if (reject) begin
          err <= 1'b1;
        end else if (is_commit) begin
          value       <= digits;
          value_valid <= 1'b1;
          digits      <= 32'h0;
          cnt         <= 4'd0;
          show        <= 1'b1;
        end else if (is_esc) begin
          digits <= 32'h0;
          cnt    <= 4'd0;
          show   <= 1'b0;
        end else if (is_hex) begin
          digits <= {digits[27:0], nib};
          cnt    <= cnt + 4'd1;
          show   <= 1'b0;
        end else begin
          digits <= {4'h0, digits[31:4]};
          cnt    <= cnt - 4'd1;
          show   <= 1'b0;
        end
      end

      hex_digits <= show ? value : digits;
      blank      <= show ? lz_blank : entry_blank;
      dec_points <= (timer != '0) ? 8'hFF : (show ? 8'h01 : 8'h00);
    end
  end

endmodule

// File: tb/tb_uart_hex_entry_buffer.sv
// Bench for uart_hex_entry_buffer: directed scenarios plus random byte streams against a nibble-queue model.
module tb_uart_hex_entry_buffer;

  localparam int ERR_CYCLES = 6;
  localparam bit LF_COMMITS = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] hex_digits;
  logic [7:0]  blank;
  logic [7:0]  dec_points;
  logic [31:0] value;
  logic        value_valid;
  logic        err;

  int checks   = 0;
  int failures = 0;

  uart_hex_entry_buffer #(.ERR_CYCLES(ERR_CYCLES), .LF_COMMITS(LF_COMMITS)) dut (
    .CLOCK_100  (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .hex_digits (hex_digits),
    .blank      (blank),
    .dec_points (dec_points),
    .value      (value),
    .value_valid(value_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Reference model: the entry is a queue of nibbles, oldest (most significant) first.
  logic [3:0]  mq[$];
  bit          m_show    = 0;
  int          m_timer   = 0;
  logic [31:0] m_value   = 0;
  bit          m_pending = 0;
  logic [7:0]  m_byte    = 0;
  bit          m_ready   = 1;
  bit          m_err     = 0;
  bit          m_vv      = 0;
  logic [31:0] e_hex     = 0;
  logic [7:0]  e_blank   = 8'hFE;
  logic [7:0]  e_dp      = 0;

  function automatic logic [31:0] pack_q();
    logic [31:0] v = 0;
    foreach (mq[i]) v = (v << 4) | 32'(mq[i]);
    return v;
  endfunction

  task automatic m_apply(input logic [7:0] b);
    int  hv  = -1;
    bit  rej = 0;
    if (b >= "0" && b <= "9")      hv = int'(b) - int'("0");
    else if (b >= "A" && b <= "F") hv = int'(b) - int'("A") + 10;
    else if (b >= "a" && b <= "f") hv = int'(b) - int'("a") + 10;
    if (hv >= 0) begin
      if (mq.size() < 8) begin m_show = 0; mq.push_back(4'(hv)); end
      else rej = 1;
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (mq.size() > 0) begin m_show = 0; void'(mq.pop_back()); end
      else rej = 1;
    end else if (b == 8'h1B) begin
      mq.delete();
      m_show = 0;
    end else if (b == 8'h0D || (LF_COMMITS && b == 8'h0A)) begin
      m_value = pack_q();
      m_vv    = 1;
      mq.delete();
      m_show  = 1;
    end else begin
      rej = 1;
    end
    if (rej) begin
      m_err   = 1;
      m_timer = ERR_CYCLES - 1;
    end else if (m_timer > 0) begin
      m_timer--;
    end
  endtask

  task automatic m_display();
    int hi = 0;
    if (m_show) begin
      e_hex = m_value;
      for (int i = 0; i < 8; i++) if (m_value[i*4 +: 4] != 0) hi = i;
      for (int i = 0; i < 8; i++) e_blank[i] = (i > hi);
    end else begin
      e_hex = pack_q();
      for (int i = 0; i < 8; i++) e_blank[i] = (i >= mq.size()) && (i != 0);
    end
    e_dp = (m_timer > 0) ? 8'hFF : (m_show ? 8'h01 : 8'h00);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        m_show = 0; m_timer = 0; m_value = 0; m_pending = 0;
        m_ready = 1; m_err = 0; m_vv = 0;
        e_hex = 0; e_blank = 8'hFE; e_dp = 0;
      end else begin
        m_display();
        m_err = 0;
        m_vv  = 0;
        if (m_pending) begin
          m_apply(m_byte);
          m_pending = 0;
        end else begin
          if (m_timer > 0) m_timer--;
          if (rx_valid) begin
            m_byte    = rx_data;
            m_pending = 1;
          end
        end
        m_ready = !m_pending;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("rx_ready",    32'(rx_ready),    32'(m_ready));
      check("hex_digits",  hex_digits,       e_hex);
      check("blank",       32'(blank),       32'(e_blank));
      check("dec_points",  32'(dec_points),  32'(e_dp));
      check("value",       value,            m_value);
      check("value_valid", 32'(value_valid), 32'(m_vv));
      check("err",         32'(err),         32'(m_err));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input logic [7:0] b, input bit hold);
    bit ok = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (rx_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("handshake", 32'(ok), 32'd1);
    @(negedge clk);
    if (!hold) rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    string hexchars = "0123456789abcdefABCDEF";
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    #2 reset_n = 1'b1;
    idle(2);
    check("reset hex",   hex_digits, 32'h0);
    check("reset blank", 32'(blank), 32'hFE);
    check("reset dp",    32'(dec_points), 32'h0);
    check("reset ready", 32'(rx_ready), 32'h1);

    send_str("1A3");
    idle(3);
    check("t1 hex",   hex_digits, 32'h0000_01A3);
    check("t1 blank", 32'(blank), 32'hF8);

    send(8'h1B, 1'b0);
    send_str("12345678");
    idle(3);
    check("t2 hex8", hex_digits, 32'h1234_5678);
    send("9", 1'b0);
    @(negedge clk);
    check("t2 err", 32'(err), 32'h1);
    @(negedge clk);
    check("t2 flash", 32'(dec_points), 32'hFF);
    idle(7);
    check("t2 flash end", 32'(dec_points), 32'h00);
    check("t2 hex kept",  hex_digits, 32'h1234_5678);

    send(8'h1B, 1'b0);
    send_str("12");
    send(8'h08, 1'b0);
    idle(3);
    check("t3 bs1", hex_digits, 32'h1);
    send(8'h7F, 1'b0);
    idle(3);
    check("t3 bs2 hex",   hex_digits, 32'h0);
    check("t3 bs2 blank", 32'(blank), 32'hFE);
    send(8'h08, 1'b0);
    @(negedge clk);
    check("t3 bs err", 32'(err), 32'h1);
    idle(10);

    send_str("BEEF");
    send(8'h0D, 1'b0);
    @(negedge clk);
    check("t4 vv",    32'(value_valid), 32'h1);
    check("t4 value", value, 32'h0000_BEEF);
    @(negedge clk);
    check("t4 show blank", 32'(blank), 32'hF0);
    check("t4 show dp",    32'(dec_points), 32'h01);
    send("5", 1'b0);
    idle(3);
    check("t4 entry hex", hex_digits, 32'h5);
    check("t4 entry dp",  32'(dec_points), 32'h00);

    send(8'h1B, 1'b0);
    send("A", 1'b1);
    send("B", 1'b1);
    rx_valid = 1'b0;
    idle(3);
    check("t5 hex", hex_digits, 32'h0000_00AB);

    send("7", 1'b0);
    #2 reset_n = 1'b0;
    idle(2);
    #2 reset_n = 1'b1;
    idle(3);
    check("t6 hex",   hex_digits, 32'h0);
    check("t6 blank", 32'(blank), 32'hFE);
    check("t6 value", value, 32'h0);

    for (int n = 0; n < 600; n++) begin
      logic [7:0] b;
      int sel = $urandom_range(0, 11);
      if (sel <= 6)      b = hexchars[$urandom_range(0, 21)];
      else if (sel == 7) b = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
      else if (sel == 8) b = ($urandom_range(0, 3) == 0) ? 8'h1B : 8'h0D;
      else if (sel == 9) b = 8'h0A;
      else               b = 8'($urandom_range(0, 255));
      send(b, $urandom_range(0, 1) != 0);
      if ($urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        idle($urandom_range(0, 3));
      end
    end
    rx_valid = 1'b0;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
